// File: rtl/adders_pkg.sv
// Shared types and helpers for the multi-precision adder slice.
// Sequencer FSM encoding and counter sizing live here.
package adders_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder.
// Purely combinational; the carry walks LSB to MSB.
module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // Bit-serial carry chain, one full adder per bit
  always_comb begin
    logic cy;
    sum = '0;
    cy  = c_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    c_out = cy;
  end

endmodule

// File: rtl/multiword_adder_seq.sv
// Multi-precision add/subtract sequencer.
// Feeds one chunk per cycle through a single ripple-carry adder.
module multiword_adder_seq
  import adders_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_cin,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_cout,
  output logic                   out_ovf
);

  localparam int N  = WIDTH * WORDS;
  localparam int CW = cnt_width(WORDS);

  state_t state;
  state_t state_nx;

  logic [CW-1:0]    cnt;
  logic             carry;
  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  logic [WIDTH-1:0] ch_a;
  logic [WIDTH-1:0] ch_b;
  logic [WIDTH-1:0] ch_s;
  logic             ch_c;
  logic             last;
  logic             accept;
  logic             fire;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign last      = (cnt == CW'(WORDS - 1));
  assign ch_a      = op_a[cnt*WIDTH +: WIDTH];
  assign ch_b      = op_b[cnt*WIDTH +: WIDTH];

  ripple_carry_adder #(
    .WIDTH(WIDTH)
  ) u_rca (
    .a    (ch_a),
    .b    (ch_b),
    .c_in (carry),
    .sum  (ch_s),
    .c_out(ch_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: accept, walk all chunks, hold until consumed
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last)   state_nx = DONE;
      DONE:    if (fire)   state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  // Operand latch, carry chain and result collection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          op_a  <= in_a;
          op_b  <= in_sub ? ~in_b : in_b;
          carry <= in_sub | in_cin;
          cnt   <= '0;
        end
        (state == RUN): begin
          out_sum[cnt*WIDTH +: WIDTH] <= ch_s;
          carry <= ch_c;
          cnt   <= cnt + 1'b1;
          if (last) begin
            out_cout <= ch_c;
            out_ovf  <= (op_a[N-1] == op_b[N-1])
                     && (ch_s[WIDTH-1] != op_a[N-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Self-checking bench for multiword_adder_seq.
// Directed corner cases plus random ops against an arithmetic model.
module tb_multiword_adder_seq;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int n_checks = 0;
  int n_fails  = 0;

  multiword_adder_seq #(
    .WIDTH(WIDTH),
    .WORDS(WORDS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // Arithmetic reference: {ovf, cout, sum}
  function automatic logic [33:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic cin,
                                        input logic sub);
    longint sa, sb, r;
    logic [32:0] u;
    logic [31:0] s;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      s = a - b;
      c = (a >= b);
      r = sa - sb;
    end else begin
      u = {1'b0, a} + {1'b0, b} + {32'b0, cin};
      s = u[31:0];
      c = u[32];
      r = sa + sb + longint'(cin);
    end
    v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {v, c, s};
  endfunction

  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic cin,
                        input logic sub,
                        input int hold);
    logic [33:0] m;
    int lat;
    m = model(a, b, cin, sub);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    in_cin = 1'($urandom);
    in_sub = 1'($urandom);
    check("in_ready_run", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    out_ready = 1'b0;
    check("latency", 64'(lat), 64'(WORDS));
    check("sum", 64'(out_sum), 64'(m[31:0]));
    check("cout", 64'(out_cout), 64'(m[32]));
    check("ovf", 64'(out_ovf), 64'(m[33]));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_a = $urandom;
      in_b = $urandom;
      @(posedge clk);
      #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_ready", 64'(in_ready), 64'd0);
      check("hold_sum", 64'(out_sum), 64'(m[31:0]));
      check("hold_flags", 64'({out_ovf, out_cout}), 64'(m[33:32]));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_sum"}, 64'(out_sum), 64'd0);
    check({tag, "_cout"}, 64'(out_cout), 64'd0);
    check({tag, "_ovf"}, 64'(out_ovf), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
    in_sub = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 0);
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 10);

    // Reset while the counter sits at chunk 2
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 32'hFFFF_FFFF;
    in_b = 32'h0000_0001;
    in_cin = 1'b1;
    in_sub = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrun");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 0);
    run_op(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 1);

    // Reset while holding a result in DONE
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 32'hDEAD_BEEF;
    in_b = 32'h1111_1111;
    in_sub = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (WORDS + 2) @(posedge clk);
    #2;
    check("done_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("middone");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      run_op($urandom, $urandom, 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
